// File: rtl/lrf_pkg.sv
// lrf_pkg: shared constants, sizing helper and phase type for the LRF temporal averager.
package lrf_pkg;
   localparam int PIXELS_PER_BEAT = 8;
   localparam int IMAGE_DIM = 16;
   localparam int PIXEL_W = 8;
   localparam int MAX_FUSE_LOG2 = 3;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   localparam int BEATS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int ACC_W = PIXEL_W + MAX_FUSE_LOG2;
   localparam int ADDR_W = clog2(BEATS_PER_IMAGE);
   localparam int FIDX_W = MAX_FUSE_LOG2 + 1;
   typedef enum logic {ACCUM, EMIT} state_t;
endpackage

// File: rtl/lrf_avg_lane.sv
// lrf_avg_lane: per-pixel accumulate step plus rounded divide-by-2^l of the running sum.
module lrf_avg_lane #(
   parameter int PIXEL_W = 8,
   parameter int ACC_W = 11,
   parameter int L_W = 2
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [PIXEL_W-1:0] pixel,
   input  logic [L_W-1:0]     l,
   input  logic               first_frame,
   output logic [ACC_W-1:0]   next_acc,
   output logic [PIXEL_W-1:0] avg
);
   logic [ACC_W:0] rnd;
   always_comb begin
      next_acc = (first_frame ? '0 : acc) + ACC_W'(pixel);
      rnd = (l == '0) ? '0 : (ACC_W + 1)'(1) << (l - L_W'(1));
      avg = PIXEL_W'(({1'b0, next_acc} + rnd) >> l);
   end
endmodule

// File: rtl/lrf_temporal_avg.sv
// lrf_temporal_avg: averages 2^L consecutive AXI4-Stream frames pixel-wise, emitting one frame per group.
module lrf_temporal_avg
   import lrf_pkg::*;
#(
   parameter int PIXELS_PER_BEAT = lrf_pkg::PIXELS_PER_BEAT,
   parameter int IMAGE_DIM = lrf_pkg::IMAGE_DIM,
   parameter int PIXEL_W = lrf_pkg::PIXEL_W,
   parameter int MAX_FUSE_LOG2 = lrf_pkg::MAX_FUSE_LOG2
) (
   input  logic                                  clk,
   input  logic                                  aresetn,
   input  logic [clog2(MAX_FUSE_LOG2+1)-1:0]     fuse_log2,
   input  logic                                  err_clr,
   input  logic [PIXEL_W*PIXELS_PER_BEAT-1:0]    s_tdata,
   input  logic                                  s_tvalid,
   output logic                                  s_tready,
   input  logic                                  s_tlast,
   output logic [PIXEL_W*PIXELS_PER_BEAT-1:0]    m_tdata,
   output logic                                  m_tvalid,
   input  logic                                  m_tready,
   output logic                                  m_tlast,
   output logic [MAX_FUSE_LOG2:0]                frame_idx,
   output logic                                  err_tlast
);
   localparam int N_BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int A_W = PIXEL_W + MAX_FUSE_LOG2;
   localparam int AD_W = clog2(N_BEATS);
   localparam int F_W = MAX_FUSE_LOG2 + 1;
   localparam int L_W = clog2(MAX_FUSE_LOG2 + 1);
   logic [AD_W-1:0] addr;
   logic [L_W-1:0] l_q, l_in, l_eff;
   logic [F_W-1:0] last_idx;
   state_t state;
   logic accept, at_last, group_start;
   logic [PIXELS_PER_BEAT*A_W-1:0] acc_mem [N_BEATS];
   logic [PIXELS_PER_BEAT*A_W-1:0] acc_rd, next_bus;
   logic [PIXELS_PER_BEAT*PIXEL_W-1:0] avg_bus;
   // The first beat of a group must already see the new L to pick ACCUM vs EMIT.
   always_comb begin
      group_start = (frame_idx == '0) && (addr == '0);
      l_in = ({1'b0, fuse_log2} > (L_W + 1)'(MAX_FUSE_LOG2)) ? L_W'(MAX_FUSE_LOG2) : fuse_log2;
      l_eff = group_start ? l_in : l_q;
      last_idx = (F_W'(1) << l_eff) - F_W'(1);
      state = (frame_idx == last_idx) ? EMIT : ACCUM;
      s_tready = (state == ACCUM) || !m_tvalid || m_tready;
      accept = s_tvalid && s_tready;
      at_last = addr == AD_W'(N_BEATS - 1);
      acc_rd = acc_mem[addr];
   end
   for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_lane
      lrf_avg_lane #(.PIXEL_W(PIXEL_W), .ACC_W(A_W), .L_W(L_W)) u_lane (
         .acc(acc_rd[A_W*i +: A_W]),
         .pixel(s_tdata[PIXEL_W*i +: PIXEL_W]),
         .l(l_eff),
         .first_frame(frame_idx == '0),
         .next_acc(next_bus[A_W*i +: A_W]),
         .avg(avg_bus[PIXEL_W*i +: PIXEL_W])
      );
   end
   always_ff @(posedge clk)
      if (accept && state == ACCUM) acc_mem[addr] <= next_bus;
   always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) begin
         addr <= '0;
         frame_idx <= '0;
         l_q <= '0;
         m_tvalid <= 1'b0;
         m_tdata <= '0;
         m_tlast <= 1'b0;
         err_tlast <= 1'b0;
      end else begin
         if (accept) begin
            addr <= at_last ? '0 : addr + AD_W'(1);
            if (group_start) l_q <= l_in;
            if (at_last) frame_idx <= (state == EMIT) ? '0 : frame_idx + F_W'(1);
         end
         if (accept && state == EMIT) begin
            m_tdata <= avg_bus;
            m_tvalid <= 1'b1;
            m_tlast <= at_last;
         end else if (m_tready) m_tvalid <= 1'b0;
         if (accept && (s_tlast != at_last)) err_tlast <= 1'b1;
         else if (err_clr) err_tlast <= 1'b0;
      end
endmodule

// File: tb/tb_lrf_temporal_avg.sv
// tb_lrf_temporal_avg: randomized directed checks of the temporal averager against a frame-averaging model.
module tb_lrf_temporal_avg;
   import lrf_pkg::*;
   localparam int NB = BEATS_PER_IMAGE;
   localparam int PB = PIXELS_PER_BEAT;
   logic clk = 1'b0, aresetn = 1'b0;
   logic [1:0] fuse_log2 = '0;
   logic err_clr = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
   logic [63:0] s_tdata = '0;
   logic s_tready, m_tvalid, m_tlast, err_tlast;
   logic [63:0] m_tdata;
   logic [3:0] frame_idx;
   int checks = 0, failures = 0;
   logic [7:0] pix [8][NB][PB];
   logic [64:0] exp_q[$], out_q[$];
   bit err_exp = 1'b0;
   lrf_temporal_avg dut (
      .clk(clk), .aresetn(aresetn), .fuse_log2(fuse_log2), .err_clr(err_clr),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .frame_idx(frame_idx), .err_tlast(err_tlast)
   );
   always #5 clk = ~clk;
   // Inputs change just after posedge, so a mid-cycle sample sees the handshake the next edge takes.
   always @(negedge clk)
      if (aresetn && m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   function automatic logic [63:0] pack(input int f, input int b);
      logic [63:0] r;
      for (int i = 0; i < PB; i++) r[8*i +: 8] = pix[f][b][i];
      return r;
   endfunction
   task automatic fill_rand(input int n);
      for (int f = 0; f < n; f++)
         for (int b = 0; b < NB; b++)
            for (int i = 0; i < PB; i++) pix[f][b][i] = 8'($urandom_range(0, 255));
   endtask
   task automatic fill_const(input int f, input int v);
      for (int b = 0; b < NB; b++)
         for (int i = 0; i < PB; i++) pix[f][b][i] = 8'(v);
   endtask
   task automatic build_exp(input int n);
      logic [63:0] w;
      for (int b = 0; b < NB; b++) begin
         for (int i = 0; i < PB; i++) begin
            int s = 0;
            for (int f = 0; f < n; f++) s += int'(pix[f][b][i]);
            w[8*i +: 8] = 8'((s + n / 2) / n);
         end
         exp_q.push_back({b == NB - 1, w});
      end
   endtask
   task automatic send_frame(input int f, input int n, input bit rr, input int tl_at,
                             input int mid_fuse, input int stop_at);
      for (int b = 0; b < NB; b++) begin
         bit acc;
         int tries;
         if (b == stop_at) return;
         acc = 1'b0;
         tries = 0;
         do begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata = pack(f, b);
            s_tlast = (tl_at < 0) ? (b == NB - 1) : (b == tl_at);
            m_tready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b == 5 && mid_fuse >= 0) fuse_log2 = 2'(mid_fuse);
            @(negedge clk);
            if (b == 0) chk("frame_idx", 65'(frame_idx), 65'(f));
            chk("err_tlast", 65'(err_tlast), 65'(err_exp));
            chk("s_tready", 65'(s_tready), (f < n - 1) ? 65'(1) : 65'(!m_tvalid || m_tready));
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            tries++;
         end while (!acc && tries < 200);
         if (!acc) chk("accept_timeout", 65'(0), 65'(1));
         if (s_tlast != (b == NB - 1)) err_exp = 1'b1;
         if (f == n - 1) chk("latency_valid", 65'(m_tvalid), 65'(1));
      end
      s_tvalid = 1'b0;
   endtask
   task automatic drain(input bit rr);
      int t = 0;
      s_tvalid = 1'b0;
      while (out_q.size() < exp_q.size() && t < 300) begin
         m_tready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         t++;
      end
      m_tready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("out_count", 65'(out_q.size()), 65'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) chk("out_beat", out_q[k], exp_q[k]);
      out_q.delete();
      exp_q.delete();
   endtask
   task automatic run_group(input int l_drive, input int n, input bit rr, input int tl_at, input int mid);
      fuse_log2 = 2'(l_drive);
      build_exp(n);
      for (int f = 0; f < n; f++) send_frame(f, n, rr, tl_at, (f == 1) ? mid : -1, -1);
      drain(rr);
      chk("frame_idx_end", 65'(frame_idx), 65'(0));
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 65'(m_tvalid), 65'(0));
      chk("rst_m_tdata", 65'(m_tdata), 65'(0));
      chk("rst_m_tlast", 65'(m_tlast), 65'(0));
      chk("rst_err", 65'(err_tlast), 65'(0));
      chk("rst_frame_idx", 65'(frame_idx), 65'(0));
      chk("rst_s_tready", 65'(s_tready), 65'(1));
      aresetn = 1'b1;
      for (int b = 0; b < NB; b++)
         for (int i = 0; i < PB; i++) pix[0][b][i] = 8'(7 - i + 8 * b);
      run_group(0, 1, 1'b0, -1, -1);
      run_group(0, 1, 1'b0, -1, -1);
      for (int f = 0; f < 4; f++) fill_const(f, 16 * (f + 1));
      run_group(2, 4, 1'b0, -1, -1);
      fill_const(0, 1);
      fill_const(1, 2);
      run_group(1, 2, 1'b0, -1, -1);
      for (int f = 0; f < 8; f++) fill_const(f, 255);
      run_group(3, 8, 1'b0, -1, -1);
      run_group(7, 8, 1'b0, -1, -1);
      fill_rand(2);
      run_group(1, 2, 1'b1, -1, -1);
      fill_rand(4);
      run_group(2, 4, 1'b1, -1, -1);
      fill_rand(1);
      run_group(0, 1, 1'b0, 10, -1);
      chk("err_sticky", 65'(err_tlast), 65'(1));
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      err_exp = 1'b0;
      chk("err_cleared", 65'(err_tlast), 65'(0));
      fill_rand(2);
      fuse_log2 = 2'd1;
      send_frame(0, 2, 1'b0, -1, -1, -1);
      send_frame(1, 2, 1'b0, -1, -1, 15);
      aresetn = 1'b0;
      #1;
      chk("midrst_m_tvalid", 65'(m_tvalid), 65'(0));
      chk("midrst_frame_idx", 65'(frame_idx), 65'(0));
      chk("midrst_m_tdata", 65'(m_tdata), 65'(0));
      @(posedge clk); #1;
      aresetn = 1'b1;
      out_q.delete();
      exp_q.delete();
      fill_rand(2);
      run_group(1, 2, 1'b0, -1, 0);
      fill_rand(1);
      run_group(0, 1, 1'b1, -1, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lrf_temporal_avg.md
Name: lrf_temporal_avg

Overview:
Streaming temporal fusion block for the LRF datapath. It averages N consecutive frames pixel-wise on AXI4-Stream, where N = 2^fuse_log2 is selectable at runtime up to 2^MAX_FUSE_LOG2. Frames 0..N-2 of each group accumulate into an internal per-pixel accumulator. The last frame of the group is summed, rounded, shifted and emitted as one output frame, so output frame rate is input rate / N.

Parameters:
PIXELS_PER_BEAT, 8, pixels packed per stream beat (lane i = bits [PIXEL_W*i +: PIXEL_W])
IMAGE_DIM, 16, square image side; BEATS_PER_IMAGE = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT
PIXEL_W, 8, unsigned pixel width
MAX_FUSE_LOG2, 3, max log2 of fuse count; ACC_W = PIXEL_W + MAX_FUSE_LOG2

Ports:
clk  in  1  single clock, rising edge
aresetn  in  1  asynchronous active-low reset
fuse_log2  in  clog2(MAX_FUSE_LOG2+1)  log2 N; sampled at group start only
err_clr  in  1  synchronous clear of err_tlast
s_tdata  in  PIXEL_W*PIXELS_PER_BEAT  input beat
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  input end-of-frame marker
m_tdata  out  PIXEL_W*PIXELS_PER_BEAT  averaged beat
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tlast  out  1  last beat of output frame
frame_idx  out  MAX_FUSE_LOG2+1  index of current frame within the group
err_tlast  out  1  sticky tlast-mismatch flag

Behaviour:
- Reset (async assert, sync deassert): m_tvalid=0, m_tdata=0, m_tlast=0, err_tlast=0, frame_idx=0, beat address=0, latched N=1. s_tready is combinational and follows the rules below. Accumulator memory is not reset.
- Accept = s_tvalid & s_tready. Beat address counts 0..BEATS_PER_IMAGE-1 and wraps. A frame ends on the beat accepted at address BEATS_PER_IMAGE-1, regardless of tlast.
- When frame_idx=0 and address=0 on an accepted beat, fuse_log2 is latched as L. Changes mid-group are ignored. Values above MAX_FUSE_LOG2 saturate to MAX_FUSE_LOG2.
- ACCUM (frame_idx < 2^L-1):
  - s_tready=1 unconditionally.
  - Frame 0: acc[addr] = zero-extended pixel.
  - Later frames: acc[addr] = acc[addr] + pixel.
  - No output. frame_idx increments at frame end.
- EMIT (frame_idx = 2^L-1; with L=0 every frame is EMIT):
  - s_tready = !m_tvalid | m_tready.
  - On accept, each lane computes (acc + pixel + (L>0 ? 2^(L-1) : 0)) >> L. With L=0 the result is the pixel itself and acc is not read.
  - The result is registered to m_tdata one cycle after accept. m_tvalid is set; m_tlast = (addr == BEATS_PER_IMAGE-1).
  - m_tvalid clears on m_tready with no new accept.
  - At frame end frame_idx returns to 0.
- Accumulator: async-read, sync-write array of BEATS_PER_IMAGE words × PIXELS_PER_BEAT × ACC_W. Read and write use the same address in the same cycle (read-modify-write in one cycle). The maximum sum 2^L*(2^PIXEL_W-1) fits ACC_W, so there is no overflow and the result is ≤ 2^PIXEL_W-1.
- Latency: 1 cycle from accept to m_tvalid in EMIT. Throughput is 1 beat/cycle when m_tready=1.
- The output register holds data while m_tvalid & !m_tready. Beats are never dropped or duplicated.
- tlast check: on an accepted beat, err_tlast is set if s_tlast != (addr == BEATS_PER_IMAGE-1). The address is not resynchronised. err_tlast stays set until err_clr or reset; if err_clr and a new error coincide, set wins.
- Reset mid-frame: all counters and the output register clear immediately. The next accepted beat is treated as frame 0, address 0.

Decomposition:
- Package lrf_pkg holds:
  - derived constants BEATS_PER_IMAGE, ACC_W, ADDR_W, FIDX_W;
  - clog2 function;
  - state enum {ACCUM, EMIT} (derived from frame_idx vs latched N, kept for readability).
- One sub-module, lrf_avg_lane, is combinational per pixel:
  - inputs acc, pixel, L, first_frame;
  - outputs next_acc and rounded avg;
  - instantiated PIXELS_PER_BEAT times via generate.
- Top holds counters, latch of L, accumulator array, output register and error flag.

Test Plan:
1. fuse_log2=0, s_tdata=0x0001020304050607, incrementing by 0x08 per lane each beat, m_tready=1 -> m_tdata equals input delayed 1 cycle; m_tlast on the 32nd beat of every frame; frame_idx stays 0.
2. fuse_log2=2, four frames of constant pixels 0x10, 0x20, 0x30, 0x40 -> no m_tvalid during frames 0-2; 32 output beats all lanes 0x28; m_tlast on beat 31; frame_idx sequence 0,1,2,3,0.
3. Rounding/extremes: fuse_log2=1, frames 0x01 then 0x02 -> 0x02; fuse_log2=3, eight frames of 0xFF -> 0xFF; fuse_log2=7 (saturates to 3) -> same as 3.
4. Backpressure, fuse_log2=1:
   - m_tready=0 in ACCUM -> s_tready stays 1.
   - random m_tready in EMIT -> s_tready = !m_tvalid|m_tready; exactly 32 ordered output beats matching a scoreboard.
5. s_tlast asserted at beat 10 and absent at beat 31 -> err_tlast=1 from beat 10 onward; output frame boundary still at beat 31; err_clr pulse -> 0.
6. aresetn low at beat 15 of EMIT:
   - m_tvalid=0 immediately and frame_idx=0;
   - next 2-frame group averages correctly;
   - fuse_log2 changed mid-group has no effect until the next group.
